vga_rect_fill: RTL
==================

Name: vga_rect_fill

Overview:
- Frame-buffer writer: accepts rectangle-fill commands and drives the write port of the 640x480, 12-bit-per-pixel video memory.
- The VGA display path reads the same memory on its other port using address = x + y*640, one word per pixel.
- Generates one pixel write per cycle, clipped to the visible area.
- Used by drawing/game logic to paint solid regions: background clears, sprites, bars.

Parameters:
- H_RES, 640, pixels per row; also the row stride in memory.
- V_RES, 480, number of rows.
- AW, 19, memory address width.

Ports:
- pix_clk  in  1  single clock for the block and the memory write port
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x  in  12  left column of the rectangle
- cmd_y  in  12  top row of the rectangle
- cmd_w  in  12  width in pixels
- cmd_h  in  12  height in pixels
- cmd_color  in  12  RGB444 fill value, {R[3:0], G[3:0], B[3:0]}
- wr_stall  in  1  memory port busy; hold the current write
- mem_we  out  1  write enable to video memory
- mem_addr  out  AW  write address, x + y*H_RES
- mem_din  out  12  write data
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: state IDLE, cmd_ready=1, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0.
- FSM states: IDLE, SETUP, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register x, y, w, h, color and go to SETUP.
- SETUP (1 cycle):
  - Compute in 13 bits: x_end = min(x+w, H_RES), y_end = min(y+h, V_RES).
  - If w==0, h==0, x>=H_RES or y>=V_RES, go to DONE with no writes.
  - Otherwise set row_base = y*H_RES (the only multiply), cur_addr = row_base + x, cur_x = x, cur_y = y, and go to FILL.
- FILL:
  - mem_we=1, mem_addr=cur_addr, mem_din=color.
  - A write is committed on each edge with mem_we=1 and wr_stall=0.
  - When wr_stall=1, mem_addr, mem_din, cur_x and cur_y hold and mem_we stays 1.
- Advance after each committed write:
  - If cur_x < x_end-1: cur_x+1, cur_addr+1.
  - Else if cur_y < y_end-1: cur_y+1, row_base += H_RES, cur_addr = row_base+H_RES+x, cur_x = x.
  - Else go to DONE; mem_we=0 next cycle.
- No multiplier in the fill loop; addresses are produced incrementally.
- DONE: done=1 for one cycle, then IDLE.
- cmd_ready=1 only in IDLE; cmd_valid in any other state is ignored and not queued.
- busy=1 in SETUP, FILL and DONE.
- Latency, accept at cycle 0 and N = clipped_w*clipped_h writes, no stalls:
  - SETUP at cycle 1.
  - Writes in cycles 2..N+1.
  - done at cycle N+2.
  - cmd_ready=1 at cycle N+3.
  - Each stall cycle adds one cycle.
- Clipping boundaries:
  - Right and bottom edges are clipped; nothing ever writes at x>=H_RES or y>=V_RES.
  - A rectangle touching the last pixel writes address H_RES*V_RES-1 = 307199 and never beyond.
- Reset mid-operation: return to IDLE on the next edge, mem_we=0, no done pulse, partial writes left in memory.

Test Plan:
- Basic fill: cmd (x=10, y=5, w=4, h=2, color=0xF00) accepted at cycle 0 -> mem_we high in cycles 2..9, addrs 3210, 3211, 3212, 3213, 3850, 3851, 3852, 3853, mem_din=0xF00; done at cycle 10; cmd_ready at 11.
- Corner clip: (x=638, y=479, w=5, h=5, color=0x0F0) -> exactly 2 writes, 307198 and 307199; done at cycle 4.
- Degenerate commands: w=0 -> zero writes, done at cycle 2; x=640, w=3, h=3 -> zero writes, done at cycle 2.
- Stall: basic fill with wr_stall=1 for 3 cycles while addr=3211 -> addr 3211 held with mem_we=1, still 8 distinct writes in order, done at cycle 13.
- Busy rejection: second cmd_valid asserted during FILL -> cmd_ready=0, command ignored, only the first rectangle written.
- Reset mid-fill: rst at the 3rd write of the basic fill -> next cycle mem_we=0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/vga_rect_fill_if.sv
// Rectangle-fill command bus: one command per valid/ready handshake.
// Latency: none (wires only).
// Backpressure: the slave holds cmd_ready low while a fill is in flight.
interface vga_rect_fill_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_x;
  logic [11:0] cmd_y;
  logic [11:0] cmd_w;
  logic [11:0] cmd_h;
  logic [11:0] cmd_color;

  // Drawing logic side: issues commands.
  modport master (
    output cmd_valid,
    output cmd_x,
    output cmd_y,
    output cmd_w,
    output cmd_h,
    output cmd_color,
    input  cmd_ready
  );

  // Fill engine side: accepts commands.
  modport slave (
    input  cmd_valid,
    input  cmd_x,
    input  cmd_y,
    input  cmd_w,
    input  cmd_h,
    input  cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill into the 640x480 RGB444 frame buffer write port, clipped to the screen.
// Latency: accept at 0, setup at 1, N writes from 2, done pulse at N+2, ready again at N+3.
// Backpressure: wr_stall holds the current write; cmd_ready is high only when idle.
module vga_rect_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19
) (
  input  logic              pix_clk,
  input  logic              rst,
  vga_rect_fill_if.slave    cmd,
  input  logic              wr_stall,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [11:0]       mem_din,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Screen limits in the 13-bit domain used for the clipped end coordinates.
  localparam logic [12:0]   H_LIM    = 13'(H_RES);
  localparam logic [12:0]   V_LIM    = 13'(V_RES);
  localparam logic [AW-1:0] H_STRIDE = AW'(H_RES);

  state_t state;
  state_t state_nxt;

  // Command captured at accept.
  logic [11:0]   x_r;
  logic [11:0]   y_r;
  logic [11:0]   w_r;
  logic [11:0]   h_r;
  logic [11:0]   color_r;

  // Clipped exclusive end coordinates, fixed for the whole fill.
  logic [12:0]   x_end_r;
  logic [12:0]   y_end_r;

  // Walk state: current pixel and the address of column 0 of the current row.
  logic [12:0]   cur_x;
  logic [12:0]   cur_y;
  logic [AW-1:0] row_base;
  logic [AW-1:0] cur_addr;

  // Setup-stage arithmetic: 13-bit sums cannot overflow with 12-bit operands.
  logic [12:0]   x_sum;
  logic [12:0]   y_sum;
  logic [12:0]   x_end_c;
  logic [12:0]   y_end_c;
  logic          empty_rect;
  logic [AW-1:0] x_ext;
  logic [AW-1:0] row_base_c;

  // Fill-loop helpers.
  logic          accept;
  logic          commit;
  logic          x_last;
  logic          y_last;
  logic [AW-1:0] row_next;

  assign accept = cmd.cmd_valid && (state == IDLE);
  assign commit = (state == FILL) && !wr_stall;

  assign x_sum   = {1'b0, x_r} + {1'b0, w_r};
  assign y_sum   = {1'b0, y_r} + {1'b0, h_r};
  assign x_end_c = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign y_end_c = (y_sum > V_LIM) ? V_LIM : y_sum;

  // Nothing visible to draw: zero size or origin already off the right/bottom edge.
  assign empty_rect = (w_r == 12'd0) || (h_r == 12'd0) ||
                      ({1'b0, x_r} >= H_LIM) || ({1'b0, y_r} >= V_LIM);

  // The one multiply: row start of the top row, used only during SETUP.
  assign x_ext      = AW'(x_r);
  assign row_base_c = AW'(y_r) * H_STRIDE;

  assign x_last   = ((cur_x + 13'd1) == x_end_r);
  assign y_last   = ((cur_y + 13'd1) == y_end_r);
  assign row_next = row_base + H_STRIDE;

  // Write port is a direct view of the walk registers; both reset to zero.
  assign mem_addr = cur_addr;
  assign mem_din  = color_r;

  // State register.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    mem_we        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (cmd.cmd_valid) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = empty_rect ? DONE : FILL;
      end
      FILL: begin
        mem_we = 1'b1;
        if (commit && x_last && y_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture, setup arithmetic and the incremental address walk.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      x_r      <= '0;
      y_r      <= '0;
      w_r      <= '0;
      h_r      <= '0;
      color_r  <= '0;
      x_end_r  <= '0;
      y_end_r  <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      cur_addr <= '0;
    end else begin
      if (accept) begin
        x_r     <= cmd.cmd_x;
        y_r     <= cmd.cmd_y;
        w_r     <= cmd.cmd_w;
        h_r     <= cmd.cmd_h;
        color_r <= cmd.cmd_color;
      end

      if (state == SETUP) begin
        x_end_r  <= x_end_c;
        y_end_r  <= y_end_c;
        row_base <= row_base_c;
        cur_addr <= row_base_c + x_ext;
        cur_x    <= {1'b0, x_r};
        cur_y    <= {1'b0, y_r};
      end

      // Advance only on a committed write; a stalled write keeps everything put.
      if (commit) begin
        if (!x_last) begin
          cur_x    <= cur_x + 13'd1;
          cur_addr <= cur_addr + AW'(1);
        end else if (!y_last) begin
          cur_x    <= {1'b0, x_r};
          cur_y    <= cur_y + 13'd1;
          row_base <= row_next;
          cur_addr <= row_next + x_ext;
        end
      end
    end
  end

  // Clipping guarantee: no write ever lands outside the visible frame.
  a_addr_in_frame: assert property (@(posedge pix_clk) disable iff (rst)
    mem_we |-> (mem_addr < AW'(H_RES * V_RES)));

  // The walk column never leaves the visible row while writing.
  a_col_in_row: assert property (@(posedge pix_clk) disable iff (rst)
    mem_we |-> (cur_x < H_LIM) && (cur_y < V_LIM));

  // Completion is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge pix_clk) disable iff (rst)
    done |=> !done);

endmodule
